// File: rtl/aro_pkg.sv
// ---------------------------------------------------------------------------
// aro_pkg
// Shared definitions for the ARO run controller.
//   - aro_state_e      : run controller FSM state encoding
//   - calc_out_count() : OUT_COUNT, the number of filtered results one run
//                        produces (NUM_SAMPLES - N + 1)
//   - calc_pipe_depth(): PIPE_DEPTH, the depth of the valid/address delay
//                        line (2 + FILTER_LAT)
// No ports; imported by the controller top.
// ---------------------------------------------------------------------------
package aro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } aro_state_e;

  // OUT_COUNT: a length-N window only yields a result once it is full.
  function automatic int calc_out_count(input int num_samples, input int n);
    return num_samples - n + 1;
  endfunction

  // PIPE_DEPTH: one cycle of ROM read latency, then FILTER_LAT cycles of
  // filter latency, then one cycle to register the filter result.
  function automatic int calc_pipe_depth(input int filter_lat);
    return 2 + filter_lat;
  endfunction

endpackage

// File: rtl/aro_run_controller_rd_pointer.sv
// ---------------------------------------------------------------------------
// rd_pointer
// Modulo up/down counter used as the display readback pointer into the
// result RAM. Counts within 0 .. TOP and wraps at both ends.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointer -> 0)
//   clr        : clear to 0, wins over the step inputs
//   up, down   : single-cycle step pulses; both high means no change
//   ptr        : current pointer value
// ---------------------------------------------------------------------------
module rd_pointer #(
  parameter int WIDTH = 8,
  parameter int TOP   = 246
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] TOP_V = WIDTH'(TOP);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  // Next pointer value: clear first, then a lone up or lone down step with
  // wraparound; simultaneous up and down cancel each other.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (up && !down) begin
      ptr_d = (ptr_q == TOP_V) ? '0 : ptr_q + 1'b1;
    end else if (down && !up) begin
      ptr_d = (ptr_q == '0) ? TOP_V : ptr_q - 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/aro_run_controller.sv
// ---------------------------------------------------------------------------
// aro_run_controller
// Sequences one run of the ARO filter: streams NUM_SAMPLES ROM addresses,
// enables the length-N filter one cycle behind each ROM read, and writes one
// filtered result per full window into the result RAM. A readback pointer
// lets the display step through the results.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : single-cycle run request (ignored while busy)
//   step_up, step_down  : readback pointer step pulses
//   rom_en, rom_addr    : ROM read (1-cycle synchronous read)
//   filt_en, filt_clr   : filter consume strobe, filter window clear pulse
//   ram_wr_en/_addr     : result RAM write
//   ram_rd_addr         : readback pointer for the display
//   busy, done          : run status
// ---------------------------------------------------------------------------
module aro_run_controller
  import aro_pkg::*;
#(
  parameter int N           = 9,
  parameter int NUM_SAMPLES = 255,
  parameter int ADDR_BITS   = 8,
  parameter int FILTER_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step_up,
  input  logic                 step_down,
  output logic                 rom_en,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 filt_en,
  output logic                 filt_clr,
  output logic                 ram_wr_en,
  output logic [ADDR_BITS-1:0] ram_wr_addr,
  output logic [ADDR_BITS-1:0] ram_rd_addr,
  output logic                 busy,
  output logic                 done
);

  localparam int OUT_COUNT  = calc_out_count(NUM_SAMPLES, N);
  localparam int PIPE_DEPTH = calc_pipe_depth(FILTER_LAT);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(NUM_SAMPLES - 1);
  localparam logic [ADDR_BITS-1:0] TAP_OFFSET = ADDR_BITS'(N - 1);

  aro_state_e state_q, state_d;

  logic [ADDR_BITS-1:0]                 rom_addr_q, rom_addr_d;
  logic [PIPE_DEPTH-1:0]                valid_q, valid_d;
  logic [PIPE_DEPTH-1:0][ADDR_BITS-1:0] paddr_q, paddr_d;

  logic                 start_accept;
  logic [ADDR_BITS-1:0] tail_addr;
  logic                 tail_write;
  logic                 last_write;

  // A start only counts when no run is in progress; reset overrides it.
  assign start_accept = start && !rst && (state_q == ST_IDLE || state_q == ST_DONE);

  // The tail of the delay line is the sample whose filter result is ready
  // now; samples before the window fills produce no result.
  assign tail_addr  = paddr_q[PIPE_DEPTH-1];
  assign tail_write = valid_q[PIPE_DEPTH-1] && (tail_addr >= TAP_OFFSET);
  assign last_write = tail_write && (tail_addr == LAST_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stream the ROM, then drain the delay line until the
  // last result has been written.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start_accept)              state_d = ST_STREAM;
      ST_STREAM:        if (rom_addr_q == LAST_ADDR)   state_d = ST_DRAIN;
      ST_DRAIN:         if (last_write)                state_d = ST_DONE;
      default:                                         state_d = ST_IDLE;
    endcase
  end

  // Output logic. Addresses are forced to 0 outside their enable cycles so
  // idle outputs are quiet.
  always_comb begin
    filt_clr    = start_accept;
    rom_en      = (state_q == ST_STREAM);
    rom_addr    = rom_en ? rom_addr_q : '0;
    filt_en     = valid_q[0];
    ram_wr_en   = tail_write;
    ram_wr_addr = tail_write ? (tail_addr - TAP_OFFSET) : '0;
    busy        = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    done        = (state_q == ST_DONE);
  end

  // Datapath next values: ROM address counter and the valid/address delay
  // line that times filt_en (stage 0) and the RAM write (last stage).
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (start_accept) begin
      rom_addr_d = '0;
    end else if (state_q == ST_STREAM) begin
      rom_addr_d = rom_addr_q + 1'b1;
    end
    valid_d = {valid_q[PIPE_DEPTH-2:0], rom_en};
    paddr_d = {paddr_q[PIPE_DEPTH-2:0], rom_addr};
  end

  // Datapath registers; reset empties the delay line so an aborted run
  // cannot produce late RAM writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      valid_q    <= '0;
      paddr_q    <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      valid_q    <= valid_d;
      paddr_q    <= paddr_d;
    end
  end

  // Readback pointer, cleared by every accepted start.
  rd_pointer #(
    .WIDTH (ADDR_BITS),
    .TOP   (OUT_COUNT - 1)
  ) u_rd_pointer (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_accept),
    .up   (step_up),
    .down (step_down),
    .ptr  (ram_rd_addr)
  );

endmodule

// File: tb/tb_aro_run_controller.sv
// ---------------------------------------------------------------------------
// tb_aro_run_controller
// Directed bench for aro_run_controller with N=9, NUM_SAMPLES=16. The main
// instance uses FILTER_LAT=2; two more instances with FILTER_LAT=0 and 4
// share the same stimulus to check the write timing across latencies.
// Cycle 0 is the cycle in which start is high (sampled at the end of it).
// ---------------------------------------------------------------------------
module tb_aro_run_controller;

  logic clk = 1'b0;
  logic rst, start, step_up, step_down;

  logic       rom_en, filt_en, filt_clr, ram_wr_en, busy, done;
  logic [7:0] rom_addr, ram_wr_addr, ram_rd_addr;

  logic       rom_en0, filt_en0, filt_clr0, ram_wr_en0, busy0, done0;
  logic [7:0] rom_addr0, ram_wr_addr0, ram_rd_addr0;

  logic       rom_en4, filt_en4, filt_clr4, ram_wr_en4, busy4, done4;
  logic [7:0] rom_addr4, ram_wr_addr4, ram_rd_addr4;

  int checks_count = 0;
  int errors_count = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  aro_run_controller #(.N(9), .NUM_SAMPLES(16), .ADDR_BITS(8), .FILTER_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .step_up(step_up), .step_down(step_down),
    .rom_en(rom_en), .rom_addr(rom_addr), .filt_en(filt_en), .filt_clr(filt_clr),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
    .busy(busy), .done(done)
  );

  aro_run_controller #(.N(9), .NUM_SAMPLES(16), .ADDR_BITS(8), .FILTER_LAT(0)) dut_lat0 (
    .clk(clk), .rst(rst), .start(start), .step_up(step_up), .step_down(step_down),
    .rom_en(rom_en0), .rom_addr(rom_addr0), .filt_en(filt_en0), .filt_clr(filt_clr0),
    .ram_wr_en(ram_wr_en0), .ram_wr_addr(ram_wr_addr0), .ram_rd_addr(ram_rd_addr0),
    .busy(busy0), .done(done0)
  );

  aro_run_controller #(.N(9), .NUM_SAMPLES(16), .ADDR_BITS(8), .FILTER_LAT(4)) dut_lat4 (
    .clk(clk), .rst(rst), .start(start), .step_up(step_up), .step_down(step_down),
    .rom_en(rom_en4), .rom_addr(rom_addr4), .filt_en(filt_en4), .filt_clr(filt_clr4),
    .ram_wr_en(ram_wr_en4), .ram_wr_addr(ram_wr_addr4), .ram_rd_addr(ram_rd_addr4),
    .busy(busy4), .done(done4)
  );

  // Drives all DUT inputs for the coming cycle.
  task automatic applyStimulus(input bit s, input bit up, input bit dn, input bit r);
    start     = s;
    step_up   = up;
    step_down = dn;
    rst       = r;
  endtask

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_count++;
    if (got !== exp) begin
      errors_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packs the main instance's outputs into one word for comparison.
  function automatic logic [31:0] packOut(input logic fc, input logic re, input logic [7:0] ra,
                                          input logic fe, input logic we, input logic [7:0] wa,
                                          input logic b, input logic d, input logic [7:0] rd);
    return {2'b00, rd, d, b, wa, we, fe, ra, re, fc};
  endfunction

  // Runs one start scenario for 26 cycles, comparing the main instance every
  // cycle against the hand-derived timeline, and tracking the write stream of
  // the FILTER_LAT=0 and =4 instances when no reset interrupts the run.
  task automatic runScenario(input string name, input int lat, input bit prev_done,
                             input logic [7:0] prev_rd, input int restart_at,
                             input int reset_at, input bit step_at_start);
    int first0 = -1, cnt0 = 0, first4 = -1, cnt4 = 0;
    for (int c = 0; c < 26; c++) begin
      applyStimulus((c == 0) || (c == restart_at), step_at_start && (c == 0), 1'b0, c == reset_at);
      @(negedge clk);
      begin
        logic       e_fc, e_re, e_fe, e_we, e_b, e_d;
        logic [7:0] e_ra, e_wa, e_rd, g_ra, g_wa;
        bit         aborted;
        aborted = (reset_at >= 0) && (c > reset_at);
        e_fc = (c == 0);
        e_re = (c >= 1) && (c <= 16);
        e_ra = e_re ? 8'(c - 1) : 8'd0;
        e_fe = (c >= 2) && (c <= 17);
        e_we = (c >= 11 + lat) && (c <= 18 + lat);
        e_wa = e_we ? 8'(c - 11 - lat) : 8'd0;
        e_b  = (c >= 1) && (c <= 18 + lat);
        e_d  = (c == 0) ? prev_done : (c >= 19 + lat);
        e_rd = (c == 0) ? prev_rd : 8'd0;
        g_ra = rom_addr;
        g_wa = ram_wr_addr;
        if (aborted) begin
          {e_fc, e_re, e_ra, e_fe, e_we, e_wa, e_b, e_d, e_rd} = '0;
        end else begin
          if (!e_re) g_ra = 8'd0;
          if (!e_we) g_wa = 8'd0;
        end
        checkOutput($sformatf("%s c=%0d", name, c),
                    packOut(filt_clr, rom_en, g_ra, filt_en, ram_wr_en, g_wa, busy, done, ram_rd_addr),
                    packOut(e_fc, e_re, e_ra, e_fe, e_we, e_wa, e_b, e_d, e_rd));
      end
      if (reset_at < 0) begin
        if (ram_wr_en0) begin
          if (first0 < 0) first0 = c;
          checkOutput($sformatf("%s lat0 wr_addr c=%0d", name, c), 32'(ram_wr_addr0), 32'(cnt0));
          cnt0++;
        end
        if (ram_wr_en4) begin
          if (first4 < 0) first4 = c;
          checkOutput($sformatf("%s lat4 wr_addr c=%0d", name, c), 32'(ram_wr_addr4), 32'(cnt4));
          cnt4++;
        end
      end
      @(posedge clk);
      #1;
    end
    if (reset_at < 0) begin
      checkOutput({name, " lat0 first write"}, 32'(first0), 32'd11);
      checkOutput({name, " lat0 write count"}, 32'(cnt0), 32'd8);
      checkOutput({name, " lat4 first write"}, 32'(first4), 32'd15);
      checkOutput({name, " lat4 write count"}, 32'(cnt4), 32'd8);
    end
  endtask

  // One step pulse followed by a quiet cycle in which the pointer is checked.
  task automatic stepPulse(input bit up, input bit dn, input logic [7:0] exp, input string tag);
    applyStimulus(1'b0, up, dn, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput(tag, 32'(ram_rd_addr), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  // Main sequence: reset, nominal run, ignored restart, mid-run reset,
  // readback stepping, and start-over-step priority.
  initial begin
    logic [7:0] up_seq [9];
    up_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1};

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset outputs",
                packOut(filt_clr, rom_en, rom_addr, filt_en, ram_wr_en, ram_wr_addr, busy, done, ram_rd_addr),
                32'd0);
    @(posedge clk);
    #1;

    $display("[TB] nominal run");
    runScenario("run1", 2, 1'b0, 8'd0, -1, -1, 1'b0);

    $display("[TB] restart while busy");
    runScenario("restart", 2, 1'b1, 8'd0, 5, -1, 1'b0);

    $display("[TB] reset mid-run");
    runScenario("abort", 2, 1'b1, 8'd0, -1, 10, 1'b0);
    runScenario("after_abort", 2, 1'b0, 8'd0, -1, -1, 1'b0);

    $display("[TB] readback stepping");
    for (int i = 0; i < 9; i++) begin
      stepPulse(1'b1, 1'b0, up_seq[i], $sformatf("step_up %0d", i));
    end
    stepPulse(1'b0, 1'b1, 8'd0, "step_down 0");
    stepPulse(1'b0, 1'b1, 8'd7, "step_down wrap");
    stepPulse(1'b1, 1'b1, 8'd7, "step both");
    stepPulse(1'b0, 1'b1, 8'd6, "step_down to 6");
    stepPulse(1'b0, 1'b1, 8'd5, "step_down to 5");

    $display("[TB] start with coincident step");
    runScenario("start_step", 2, 1'b1, 8'd5, -1, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks_count, errors_count);
    $finish;
  end

endmodule
